logic_accum_unit: RTL and testbench
===================================

Name: logic_accum_unit

Overview:
- Parametrised, registered successor to the two-input AND gate lab block.
- Accepts a stream of WIDTH-bit operands over a valid/ready handshake and folds them bitwise with a selectable op (AND/OR/XOR/NAND).
- Presents the folded result, beat count and overflow flag over a second valid/ready handshake.
- Sits as a reusable datapath element between lab stimulus sources and display/checker logic.

Parameters:
WIDTH, 8, operand/result width in bits (>=1)
MAX_BEATS, 16, maximum operands per transaction (>=1)
CNT_W, $clog2(MAX_BEATS+1), width of beat counter (derived, not overridden)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
in_valid  input  1  operand beat present
in_ready  output  1  block can accept operand
in_data  input  WIDTH  operand
in_last  input  1  final operand of transaction
op  input  2  00 AND, 01 OR, 10 XOR, 11 NAND; sampled on first beat only
out_valid  output  1  result available
out_ready  input  1  consumer accepts result
out_data  output  WIDTH  folded result
out_count  output  CNT_W  beats folded into result (1..MAX_BEATS)
out_overflow  output  1  transaction terminated at MAX_BEATS without in_last

Behaviour:
- Single clock (clk); reset rst is synchronous and active-high.
- Reset (any state, mid-transaction included): state=IDLE, accumulator=0, count=0, op_q=00, out_valid=0, out_data=0, out_count=0, out_overflow=0. Partial transaction is discarded.
- Beat accepted when in_valid && in_ready on a rising edge.
- in_ready = 1 in IDLE and ACCUM, 0 in DONE. It is a combinational function of state only.
- States:
  - IDLE: on accepted beat, load accumulator with in_data, latch op into op_q, count=1. If in_last or MAX_BEATS==1, go to DONE; else go to ACCUM.
  - ACCUM: on accepted beat, accumulator = acc AND/OR/XOR in_data (NAND folds with AND), count+1. Go to DONE if in_last or count+1==MAX_BEATS. No beat means hold.
  - DONE: out_valid=1; out_data/out_count/out_overflow are stable until out_ready is high at a rising edge. Then go to IDLE and out_valid returns to 0 the next cycle.
- op changes after the first beat are ignored until the next transaction.
- out_data = accumulator, bitwise inverted when op_q==11 (NAND = NOT of AND-fold). A single-beat NAND gives ~in_data.
- out_overflow=1 only when the beat that reached MAX_BEATS had in_last=0. in_last on exactly beat MAX_BEATS gives overflow=0.
- Latency: out_valid rises the cycle after the final beat is accepted. Back-to-back throughput is one transaction per (beats+1) cycles minimum, since no beat is accepted in DONE.
- out_valid held with out_ready low holds indefinitely; outputs do not change.
- out_count, out_data and out_overflow are registered and update only on the transition into DONE.

Optional Feature:
- Macro LOGIC_ACCUM_PARITY_EN.
- Defined: extra output port out_parity (1 bit) = XOR-reduce of out_data. It is registered with the other outputs, resets to 0, and is valid with out_valid.
- Undefined: port and logic absent; all other behaviour identical.

Test Plan:
- Reset mid-ACCUM: op=00, beats 8'hF0, 8'hCC, assert rst one cycle -> out_valid stays 0, next transaction 8'h0F (last) yields out_data=8'h0F, out_count=1.
- AND fold: op=00, beats 8'hFF, 8'hF0, 8'h3C (last) -> out_data=8'h30, out_count=3, out_overflow=0, out_valid one cycle after last beat.
- XOR/NAND: op=10, beats 8'hAA, 8'h55 (last) -> 8'hFF. Then op=11, beats 8'hFF, 8'h0F (last) -> 8'hF0. Changing op to 01 on beat 2 has no effect.
- Overflow boundary (MAX_BEATS=16): op=01, 16 beats of 8'h01 with in_last=0 -> out_count=16, out_overflow=1, out_data=8'h01. Repeat with in_last on beat 16 -> out_overflow=0.
- Backpressure: hold out_ready=0 for 10 cycles in DONE while in_valid=1 -> in_ready=0, outputs stable. Raise out_ready -> IDLE next cycle and the next beat is accepted.
- With LOGIC_ACCUM_PARITY_EN: AND-fold result 8'h30 -> out_parity=0. XOR result 8'h01 -> out_parity=1. Build without the macro compiles with no out_parity port.

Source files
------------

// File: rtl/logic_accum_unit.sv
// Streaming bitwise fold (AND/OR/XOR/NAND) of WIDTH-bit operands, with a registered result handshake.
// Optional macro LOGIC_ACCUM_PARITY_EN adds out_parity (XOR-reduce of out_data).
module logic_accum_unit #(
  parameter int WIDTH     = 8,
  parameter int MAX_BEATS = 16,
  localparam int CNT_W    = $clog2(MAX_BEATS + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  input  logic [1:0]       op,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_data,
  output logic [CNT_W-1:0] out_count,
  output logic             out_overflow
`ifdef LOGIC_ACCUM_PARITY_EN
  ,output logic            out_parity
`endif
);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE} state_t;

  state_t             state, state_n;
  logic [WIDTH-1:0]   acc, acc_n, fold, res_n;
  logic [CNT_W-1:0]   count, cnt_n;
  logic [1:0]         op_q, opq_n, fold_op;
  logic               fin, ovf_n;

  // op is only live on the first beat; later beats fold with the latched op
  always_comb begin
    fold_op = (state == IDLE) ? op : op_q;
    case (fold_op)
      2'b01:   fold = acc | in_data;
      2'b10:   fold = acc ^ in_data;
      default: fold = acc & in_data;
    endcase
  end

  always_comb begin
    state_n   = state;
    acc_n     = acc;
    cnt_n     = count;
    opq_n     = op_q;
    fin       = 1'b0;
    in_ready  = (state != DONE);
    out_valid = (state == DONE);
    case (state)
      IDLE: if (in_valid) begin
        acc_n   = in_data;
        cnt_n   = CNT_W'(1);
        opq_n   = op;
        fin     = in_last || (MAX_BEATS == 1);
        state_n = fin ? DONE : ACCUM;
      end
      ACCUM: if (in_valid) begin
        acc_n   = fold;
        cnt_n   = count + 1'b1;
        fin     = in_last || (cnt_n == CNT_W'(MAX_BEATS));
        state_n = fin ? DONE : ACCUM;
      end
      DONE: if (out_ready) state_n = IDLE;
      default: state_n = IDLE;
    endcase
    ovf_n = !in_last && (cnt_n == CNT_W'(MAX_BEATS));
    res_n = (opq_n == 2'b11) ? ~acc_n : acc_n;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state        <= IDLE;
      acc          <= '0;
      count        <= '0;
      op_q         <= 2'b00;
      out_data     <= '0;
      out_count    <= '0;
      out_overflow <= 1'b0;
`ifdef LOGIC_ACCUM_PARITY_EN
      out_parity   <= 1'b0;
`endif
    end else begin
      state <= state_n;
      acc   <= acc_n;
      count <= cnt_n;
      op_q  <= opq_n;
      // result registers move only on the edge that enters DONE
      if (fin) begin
        out_data     <= res_n;
        out_count    <= cnt_n;
        out_overflow <= ovf_n;
`ifdef LOGIC_ACCUM_PARITY_EN
        out_parity   <= ^res_n;
`endif
      end
    end
  end

endmodule

// File: tb/tb_logic_accum_unit.sv
// Bench for logic_accum_unit: directed scenarios with literal results plus a random run
// checked every cycle against a transaction-level model.
module tb_logic_accum_unit;
  localparam int WIDTH = 8;
  localparam int MAXB  = 16;
  localparam int CW    = $clog2(MAXB + 1);

  logic             clk = 0, rst = 1;
  logic             in_valid = 0, in_last = 0, out_ready = 0;
  logic [WIDTH-1:0] in_data = '0;
  logic [1:0]       op = 2'b00;
  logic             in_ready, out_valid, out_overflow;
  logic [WIDTH-1:0] out_data;
  logic [CW-1:0]    out_count;
`ifdef LOGIC_ACCUM_PARITY_EN
  logic             out_parity;
`endif

  logic_accum_unit #(.WIDTH(WIDTH), .MAX_BEATS(MAXB)) dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last), .op(op),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_count(out_count), .out_overflow(out_overflow)
`ifdef LOGIC_ACCUM_PARITY_EN
    , .out_parity(out_parity)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  bit chk_en = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---- transaction-level model ----
  logic [WIDTH-1:0] beats[$];
  logic [1:0]       cur_op;
  bit               m_valid = 0;
  logic [WIDTH-1:0] m_data = '0;
  int               m_count = 0;
  bit               m_ovf = 0;

  function automatic logic [WIDTH-1:0] fold_all(input logic [1:0] o);
    logic [WIDTH-1:0] r = beats[0];
    for (int i = 1; i < beats.size(); i++)
      case (o)
        2'b01:   r = r | beats[i];
        2'b10:   r = r ^ beats[i];
        default: r = r & beats[i];
      endcase
    return (o == 2'b11) ? ~r : r;
  endfunction

  always @(posedge clk) begin
    if (rst) begin
      beats.delete(); m_valid = 0; m_data = '0; m_count = 0; m_ovf = 0;
    end else if (m_valid) begin
      if (out_ready) m_valid = 0;
    end else if (in_valid) begin
      if (beats.size() == 0) cur_op = op;
      beats.push_back(in_data);
      if (in_last || beats.size() == MAXB) begin
        m_data  = fold_all(cur_op);
        m_count = beats.size();
        m_ovf   = !in_last;
        m_valid = 1;
        beats.delete();
      end
    end
  end

  always @(negedge clk) if (chk_en) begin
    chk("in_ready",  {31'b0, in_ready},  {31'b0, !m_valid});
    chk("out_valid", {31'b0, out_valid}, {31'b0, m_valid});
    chk("out_data",  32'(out_data),      32'(m_data));
    chk("out_count", 32'(out_count),     32'(m_count));
    chk("out_ovf",   {31'b0, out_overflow}, {31'b0, m_ovf});
`ifdef LOGIC_ACCUM_PARITY_EN
    chk("out_parity", {31'b0, out_parity}, {31'b0, ^m_data});
`endif
  end

  // ---- directed helpers ----
  task automatic beat(input logic [7:0] d, input bit last, input logic [1:0] o);
    int n = 0;
    in_valid = 1; in_data = d; in_last = last; op = o;
    while (!in_ready && n < 50) begin @(negedge clk); #1; n++; end
    if (!in_ready) chk("beat_timeout", 32'd1, 32'd0);
    @(negedge clk); #1;
    in_valid = 0; in_last = 0;
  endtask

  task automatic result(input string nm, input logic [7:0] d, input int c, input bit ov);
    int n = 0;
    while (!out_valid && n < 50) begin @(negedge clk); #1; n++; end
    chk({nm, "_valid"}, {31'b0, out_valid}, 32'd1);
    chk({nm, "_data"},  32'(out_data),  32'(d));
    chk({nm, "_count"}, 32'(out_count), 32'(c));
    chk({nm, "_ovf"},   {31'b0, out_overflow}, {31'b0, ov});
    out_ready = 1;
    @(negedge clk); #1;
    out_ready = 0;
  endtask

  initial begin
    repeat (2) @(negedge clk);
    #1 rst = 0; chk_en = 1;
    chk("rst_valid", {31'b0, out_valid}, 32'd0);
    chk("rst_ready", {31'b0, in_ready}, 32'd1);
    chk("rst_data",  32'(out_data), 32'd0);

    // reset in the middle of a transaction drops it
    beat(8'hF0, 0, 2'b00); beat(8'hCC, 0, 2'b00);
    rst = 1; @(negedge clk); #1; rst = 0;
    chk("midrst_valid", {31'b0, out_valid}, 32'd0);
    beat(8'h0F, 1, 2'b00);
    result("midrst", 8'h0F, 1, 0);

    beat(8'hFF, 0, 2'b00); beat(8'hF0, 0, 2'b00); beat(8'h3C, 1, 2'b00);
    chk("and_lat", {31'b0, out_valid}, 32'd1);
`ifdef LOGIC_ACCUM_PARITY_EN
    chk("par_and", {31'b0, out_parity}, 32'd0);
`endif
    result("and", 8'h30, 3, 0);

    beat(8'hAA, 0, 2'b10); beat(8'h55, 1, 2'b10);
    result("xor", 8'hFF, 2, 0);
    beat(8'hFF, 0, 2'b11); beat(8'h0F, 1, 2'b01);
    result("nand", 8'hF0, 2, 0);
    beat(8'h5A, 1, 2'b11);
    result("nand1", 8'hA5, 1, 0);

    beat(8'h03, 0, 2'b10); beat(8'h02, 1, 2'b10);
`ifdef LOGIC_ACCUM_PARITY_EN
    chk("par_xor", {31'b0, out_parity}, 32'd1);
`endif
    result("xor01", 8'h01, 2, 0);

    for (int i = 0; i < 16; i++) beat(8'h01, 0, 2'b01);
    result("ovf", 8'h01, 16, 1);
    for (int i = 0; i < 16; i++) beat(8'h01, i == 15, 2'b01);
    result("last16", 8'h01, 16, 0);

    // backpressure: result held while a new beat waits
    beat(8'hFF, 0, 2'b00); beat(8'h3C, 1, 2'b00);
    in_valid = 1; in_data = 8'hAA; in_last = 1; op = 2'b10;
    for (int i = 0; i < 10; i++) begin
      chk("bp_ready", {31'b0, in_ready}, 32'd0);
      chk("bp_data", 32'(out_data), 32'h3C);
      @(negedge clk); #1;
    end
    out_ready = 1; @(negedge clk); #1; out_ready = 0;
    chk("bp_idle_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk); #1; in_valid = 0; in_last = 0;
    result("bp_next", 8'hAA, 1, 0);

    // random traffic
    for (int cyc = 0; cyc < 4000; cyc++) begin
      in_valid  = ($urandom_range(3) != 0);
      in_data   = 8'($urandom);
      in_last   = ($urandom_range(19) == 0);
      op        = 2'($urandom);
      out_ready = ($urandom_range(2) != 0);
      rst       = ($urandom_range(599) == 0);
      @(negedge clk); #1;
    end
    rst = 0; in_valid = 0; out_ready = 1;
    repeat (3) @(negedge clk);
    #1;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
